// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter.
// Shares one write port between the in-order pipeline write-back and results
// from the long-latency multiply/divide unit (MDU), which are held in a small
// FIFO. One write is granted per cycle, and the port outputs are registered.
//
// Handshakes: a pipeline write is consumed in any cycle where
// pipe_valid_i & pipe_ready_o. An MDU result is consumed in any cycle where
// mdu_valid_i & mdu_ready_o. The producer holds its payload stable until it is
// consumed. pipe_ready_o is combinational, and mdu_ready_o depends only on
// registered state.
module wb_port_arbiter #(
  parameter int DWIDTH       = 32,
  parameter int RWIDTH       = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pipe_valid_i,
  input  logic [RWIDTH-1:0]             pipe_rd_i,
  input  logic [DWIDTH-1:0]             pipe_data_i,
  output logic                          pipe_ready_o,
  input  logic                          mdu_valid_i,
  input  logic [RWIDTH-1:0]             mdu_rd_i,
  input  logic [DWIDTH-1:0]             mdu_data_i,
  output logic                          mdu_ready_o,
  output logic                          rf_we_o,
  output logic [RWIDTH-1:0]             rf_rd_o,
  output logic [DWIDTH-1:0]             rf_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   q_count_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [RWIDTH-1:0] q_rd   [FIFO_DEPTH];
  logic [DWIDTH-1:0] q_data [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [SW-1:0]     starve;

  logic q_nonempty;
  logic push;
  logic q_grant;
  logic waw_hit;
  logic pipe_rd_nz;
  logic starved;

  assign q_nonempty = (count != '0);
  assign pipe_rd_nz = (pipe_rd_i != '0);
  assign starved    = (starve == SW'(STARVE_LIMIT));
  assign mdu_ready_o = (count != CW'(FIFO_DEPTH));
  assign push       = mdu_valid_i & mdu_ready_o;
  assign q_count_o  = count;

  // WAW check: the pipeline rd matches any occupied queue slot.
  always_comb begin
    waw_hit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (({1'b0, PW'(i) - rd_ptr} < count) && (q_rd[i] == pipe_rd_i) && pipe_rd_nz)
        waw_hit = 1'b1;
    end
  end

  // The queue head takes the port when the pipe does not need it, is starving, or must retire first.
  always_comb begin
    q_grant = q_nonempty & (~pipe_valid_i | ~pipe_rd_nz | starved | waw_hit);
    pipe_ready_o = ~q_grant | ~pipe_rd_nz;
  end

  // Queue storage writes. Data is left unreset because occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= mdu_rd_i;
      q_data[wr_ptr] <= mdu_data_i;
    end
  end

  // Queue pointers and occupancy. A push lands behind the head, so it never bypasses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (q_grant) rd_ptr <= rd_ptr + 1'b1;
      if (push && !q_grant)      count <= count + CW'(1);
      else if (!push && q_grant) count <= count - CW'(1);
    end
  end

  // Starvation counter: counts cycles where a waiting queue loses the port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve <= '0;
    end else if (!q_nonempty || q_grant) begin
      starve <= '0;
    end else if (!starved) begin
      starve <= starve + SW'(1);
    end
  end

  // Registered port write. rd=0 targets never assert the write enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we_o   <= 1'b0;
      rf_rd_o   <= '0;
      rf_data_o <= '0;
    end else if (q_grant) begin
      rf_we_o   <= (q_rd[rd_ptr] != '0);
      rf_rd_o   <= q_rd[rd_ptr];
      rf_data_o <= q_data[rd_ptr];
    end else if (pipe_valid_i && pipe_ready_o && pipe_rd_nz) begin
      rf_we_o   <= 1'b1;
      rf_rd_o   <= pipe_rd_i;
      rf_data_o <= pipe_data_i;
    end else begin
      rf_we_o   <= 1'b0;
    end
  end

endmodule
